// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register dump reader.
// The CSUM state exists only when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_pkg;

  localparam int DEF_NUM_REGS  = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int BYTES_PER_REG = DEF_DATA_W / 8;

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/reg_dump_byte_sel.sv
// Combinational byte picker: byte index -> byte of the snapshot,
// register 0 first, each register least-significant byte first.
module reg_dump_byte_sel
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SEL_W    = 6
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] i_snap,
  input  logic [SEL_W-1:0]                i_idx,
  output logic [7:0]                      o_byte
);

  localparam int TOTAL = NUM_REGS * (DATA_W / 8);

  // Packed layout already puts register 0 / byte 0 at the bottom.
  logic [TOTAL-1:0][7:0] w_bytes;

  assign w_bytes = i_snap;
  assign o_byte  = w_bytes[i_idx];

endmodule

// File: rtl/reg_dump_reader.sv
// Snapshots a register file on start and streams it out byte by byte.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte after the data.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] registers,
  input  logic                            start,
  output logic [7:0]                      out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output state_t                          o_dbg_state
);

  localparam int TOTAL = NUM_REGS * (DATA_W / 8);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int SEL_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit LAST_ON_DATA = 1'b0;
`else
  localparam bit LAST_ON_DATA = 1'b1;
`endif

  state_t                          r_state;
  logic [NUM_REGS-1:0][DATA_W-1:0] r_snap;
  logic [CNT_W-1:0]                r_cnt;
  logic [7:0]                      r_out_data;
  logic                            r_out_valid;
  logic                            r_out_last;
  logic                            r_busy;
  logic                            r_done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]                      r_csum;
`endif

  logic             w_fire;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_last_data;
  logic [7:0]       w_next_byte;

  // Handshake: a byte moves on a rising edge where out_valid && out_ready;
  // out_valid is a register, so it never follows out_ready combinationally,
  // and out_data/out_last only change on a transfer.
  assign w_fire      = r_out_valid & out_ready;
  assign w_next_cnt  = r_cnt + CNT_W'(1);
  assign w_last_data = (r_cnt == CNT_W'(TOTAL - 1));

  reg_dump_byte_sel #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .SEL_W    (SEL_W)
  ) u_byte_sel (
    .i_snap (r_snap),
    .i_idx  (w_next_cnt[SEL_W-1:0]),
    .o_byte (w_next_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Byte 0 comes straight from the bus, matching what the snapshot captures.
            r_snap      <= registers;
            r_cnt       <= '0;
            r_out_data  <= registers[0][7:0];
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= SEND;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum      <= '0;
`endif
          end
        end
        SEND: begin
          if (w_fire) begin
            r_cnt <= w_next_cnt;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum <= r_csum ^ r_out_data;
`endif
            if (w_last_data) begin
`ifdef REG_DUMP_CHECKSUM_EN
              r_out_data <= r_csum ^ r_out_data;
              r_out_last <= 1'b1;
              r_state    <= CSUM;
`else
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= IDLE;
`endif
            end else begin
              r_out_data <= w_next_byte;
              r_out_last <= LAST_ON_DATA && (w_next_cnt == CNT_W'(TOTAL - 1));
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (w_fire) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected bytes are queued at start
// and compared as the DUT hands them over.
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 32;
  localparam int TOTAL    = NUM_REGS * DATA_W / 8;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit HAS_CSUM = 1'b1;
`else
  localparam bit HAS_CSUM = 1'b0;
`endif
  localparam int DUMP_LEN = TOTAL + (HAS_CSUM ? 1 : 0);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                            start = 1'b0;
  logic                            out_ready = 1'b0;
  logic [NUM_REGS-1:0][DATA_W-1:0] registers = '0;
  logic [7:0]                      out_data;
  logic                            out_valid;
  logic                            out_last;
  logic                            busy;
  logic                            done;
  state_t                          dbg_state;

  reg_dump_reader #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .registers   (registers),
    .start       (start),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         ready_mode = 0;
  int         xfer_cnt = 0;
  bit         done_exp = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  logic       stall_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_dump();
    logic [DATA_W-1:0] r;
    logic [7:0]        b;
    logic [7:0]        cs;
    logic              lst;
    cs = '0;
    for (int k = 0; k < TOTAL; k++) begin
      r   = registers[k / BYTES_PER_REG];
      b   = r[8 * (k % BYTES_PER_REG) +: 8];
      cs  = cs ^ b;
      lst = !HAS_CSUM && (k == TOTAL - 1);
      exp_q.push_back({lst, b});
    end
    if (HAS_CSUM) exp_q.push_back({1'b1, cs});
  endtask

  task automatic pulse_start(input bit accept);
    @(posedge clk); #2;
    start = 1'b1;
    if (accept) push_dump();
    @(posedge clk); #2;
    start = 1'b0;
    if (accept) begin
      check("valid_after_start", out_valid, 1'b1);
      check("busy_after_start", busy, 1'b1);
    end
  endtask

  task automatic wait_drain(input int budget, input string tag, output int cycles);
    cycles = 0;
    while ((exp_q.size() != 0 || busy) && cycles < budget) begin
      @(posedge clk);
      cycles++;
    end
    check({tag, "_complete"}, (exp_q.size() == 0 && !busy), 1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
        done_exp   = 1'b0;
      end else begin
        if (done || done_exp) check("done_pulse", done, done_exp);
        if (done_exp) check("valid_low_on_done", out_valid, 1'b0);
        if (busy || out_valid) check("busy_vs_valid", busy, out_valid);
        if (stall_prev) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_data", out_data, stall_data);
          check("stall_last", out_last, stall_last);
        end
        done_exp = 1'b0;
        if (out_valid && out_ready) begin
          check("queue_has_entry", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("byte_data", out_data, exp_e[7:0]);
            check("byte_last", out_last, exp_e[8]);
          end
          xfer_cnt++;
          if (out_last) done_exp = 1'b1;
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int cycles;
    int n;

    // reset state
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_last", out_last, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_no_valid", out_valid, 1'b0);
    end

    // incrementing pattern, always ready
    for (int i = 0; i < NUM_REGS; i++) registers[i] = 32'h11223300 + i;
    ready_mode = 0;
    xfer_cnt = 0;
    pulse_start(1'b1);
    wait_drain(200, "basic", cycles);
    check("basic_count", xfer_cnt, DUMP_LEN);

    // ready toggling every cycle
    for (int i = 0; i < NUM_REGS; i++) registers[i] = $urandom;
    ready_mode = 1;
    xfer_cnt = 0;
    pulse_start(1'b1);
    wait_drain(400, "toggle", cycles);
    check("toggle_count", xfer_cnt, DUMP_LEN);
    check("toggle_len_ok", cycles <= 2 * DUMP_LEN + 10, 1'b1);

    // registers change and a second start mid-dump: both ignored
    for (int i = 0; i < NUM_REGS; i++) registers[i] = $urandom;
    ready_mode = 2;
    xfer_cnt = 0;
    pulse_start(1'b1);
    repeat (10) @(posedge clk);
    #2;
    for (int i = 0; i < NUM_REGS; i++) registers[i] = ~registers[i];
    pulse_start(1'b0);
    wait_drain(600, "snapshot", cycles);
    check("snapshot_count", xfer_cnt, DUMP_LEN);
    repeat (3) @(negedge clk);
    check("no_second_dump", out_valid, 1'b0);

    // reset in the middle of a dump
    ready_mode = 0;
    xfer_cnt = 0;
    pulse_start(1'b1);
    n = 0;
    while (xfer_cnt < 21 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("reached_byte20", xfer_cnt >= 21, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", out_data, 8'h00);
    check("midrst_last", out_last, 1'b0);
    check("midrst_done", done, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 1'b0);
    end
    xfer_cnt = 0;
    pulse_start(1'b1);
    wait_drain(200, "after_rst", cycles);
    check("after_rst_count", xfer_cnt, DUMP_LEN);

    // checksum-oriented patterns
    for (int i = 0; i < NUM_REGS; i++) registers[i] = 32'hA5A5A5A5;
    pulse_start(1'b1);
    wait_drain(200, "pattern_a5", cycles);
    registers = '0;
    registers[0] = 32'h000000FF;
    pulse_start(1'b1);
    wait_drain(200, "pattern_ff", cycles);

    // start held high through done: back-to-back dumps
    for (int i = 0; i < NUM_REGS; i++) registers[i] = $urandom;
    ready_mode = 0;
    xfer_cnt = 0;
    @(posedge clk); #2;
    start = 1'b1;
    push_dump();
    push_dump();
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("b2b_done_seen", done, 1'b1);
    check("b2b_valid_in_done", out_valid, 1'b0);
    @(posedge clk); #2;
    start = 1'b0;
    check("b2b_valid_next", out_valid, 1'b1);
    check("b2b_busy_next", busy, 1'b1);
    wait_drain(300, "b2b", cycles);
    check("b2b_count", xfer_cnt, 2 * DUMP_LEN);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers dumped.
REQ-002 SHALL have parameter DATA_W, default 32, register width in bits (multiple of 8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port registers, input, NUM_REGS x DATA_W, the register file contents bus.
REQ-006 SHALL have port start, input, 1, dump request.
REQ-007 SHALL have port out_data, output, 8, the current byte.
REQ-008 SHALL have port out_valid, output, 1, out_data is valid.
REQ-009 SHALL have port out_ready, input, 1, the consumer accepts the byte.
REQ-010 SHALL have port out_last, output, 1, the final byte of the dump.
REQ-011 SHALL have port busy, output, 1, a dump is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last byte is accepted.

Function
REQ-013 SHALL implement states IDLE, SEND and, with the macro, CSUM.
REQ-014 IDLE with start=1 at an edge SHALL capture all registers into a snapshot, clear the byte counter and enter SEND; out_valid and busy go high the following cycle.
REQ-015 start SHALL be ignored outside IDLE; the snapshot SHALL NOT change during a dump.
REQ-016 Byte order SHALL be register 0 first, each register least-significant byte first (byte k = snapshot[k/4][8*(k%4)+:8]).
REQ-017 A transfer SHALL occur only on an edge with out_valid=1 and out_ready=1; the byte counter then increments by 1.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-019 The total SHALL be NUM_REGS*DATA_W/8 data bytes (64 at default); the counter SHALL be sized to hold that count exactly, with no wrap within a dump.
REQ-020 out_last SHALL be high only with the final byte of the dump.
REQ-021 After the final transfer the block SHALL return to IDLE, drop out_valid and busy, and pulse done for exactly one cycle.
REQ-022 A start that coincides with the done cycle SHALL be accepted, because the block is already in IDLE.
REQ-023 out_valid SHALL never depend combinationally on out_ready.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, clear the counter and snapshot, and drive out_valid=0, out_last=0, busy=0, done=0 and out_data=0, including mid-dump.
REQ-025 After rst is released, no byte SHALL be emitted until a new start.

Configuration
REQ-026 With REG_DUMP_CHECKSUM_EN defined, after the final data byte the block SHALL enter CSUM and emit one extra byte equal to the XOR of all data bytes.
REQ-027 With REG_DUMP_CHECKSUM_EN defined, out_last SHALL move to the checksum byte, for a total of 65 bytes.
REQ-028 Without REG_DUMP_CHECKSUM_EN, the CSUM state and the accumulator SHALL be absent and the behaviour SHALL be exactly as in REQ-019 to REQ-021.

Structure
REQ-029 The state enum, NUM_REGS/DATA_W defaults and BYTES_PER_REG constant SHALL live in package reg_dump_pkg.
REQ-030 Byte selection from the snapshot SHALL be a combinational sub-module reg_dump_byte_sel (index -> byte).

Verification
REQ-031 Scenario: registers[i]=32'h11223300+i, start pulse, out_ready=1 -> bytes 00,33,22,11,01,33,22,11,...; 64 bytes; out_last on byte 63 (0x11); done 1 cycle later.
REQ-032 Scenario: out_ready toggled 1/0 every cycle -> no byte lost or duplicated; data stable while stalled; dump completes in ~128 cycles.
REQ-033 Scenario: change registers and pulse start again mid-dump -> output matches the original snapshot, and the second start is ignored.
REQ-034 Scenario: rst=0 after byte 20 -> out_valid=0 immediately; a new start restarts at byte 0.
REQ-035 Scenario: REG_DUMP_CHECKSUM_EN defined, all registers 32'hA5A5A5A5 -> 65th byte 0x00 with out_last; with registers[0]=32'h000000FF and the rest 0 -> checksum 0xFF.
REQ-036 Scenario: start held high through done -> a back-to-back second dump starts in the cycle after done with byte 0.
